// File: rtl/msk_bb_mod.sv
// msk_bb_mod: MSK baseband modulator (offset-QPSK, half-sine pulses), serial bits -> 16-bit signed I/Q for the DUC.
// Latency: I_data/Q_data/out_valid update one clk after each en && sample_en cycle; outputs hold between strobes.
// Backpressure: one-entry bit holding register, bit_tready = !full; symbol slots never stall (empty slot -> zero + underrun).
// Ports: clk, reset (async, active-high); en, sample_en sequencing; bit_tdata/bit_tvalid/bit_tready bit stream;
//        I_data/Q_data/out_valid sample output; underrun sticky while en is high.
module msk_bb_mod #(
    parameter int SPS = 8,
    parameter int AMP = 16384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               sample_en,
    input  logic               bit_tdata,
    input  logic               bit_tvalid,
    output logic               bit_tready,
    output logic signed [15:0] I_data,
    output logic signed [15:0] Q_data,
    output logic               out_valid,
    output logic               underrun
);
    localparam int            NP     = 2 * SPS;
    localparam int            CW     = $clog2(NP);
    localparam logic [CW-1:0] SPS_C  = CW'(SPS);
    localparam logic [CW-1:0] LAST_C = CW'(NP - 1);
    localparam real           PI     = 3.14159265358979323846;

    // Symbol encoding {negative, nonzero}: zero, +1, -1.
    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b11;

    // Half-sine magnitude table, rounded to nearest; always in 0..AMP.
    function automatic logic [15:0] lut_val(input int k);
        real x;
        x = real'(AMP) * $sin(PI * real'(k) / real'(NP));
        return 16'($rtoi(x + 0.5));
    endfunction

    function automatic logic signed [15:0] shape(input logic [1:0] sym, input logic [15:0] mag);
        if (!sym[0]) begin
            return '0;
        end
        return sym[1] ? -$signed(mag) : $signed(mag);
    endfunction

    logic [15:0] lut [NP];
    for (genvar k = 0; k < NP; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    logic [CW-1:0]      n_cnt_q, n_cnt_d, q_idx;
    logic [1:0]         sym_i_q, sym_i_d, sym_q_q, sym_q_d, slot_sym;
    logic               hold_v_q, hold_v_d, hold_bit_q, hold_bit_d;
    logic signed [15:0] i_q, i_d, q_q, q_d;
    logic               vld_q, vld_d, under_q, under_d;

    // Q pulse runs half a symbol (SPS samples) behind I: index (n + SPS) mod 2*SPS.
    assign q_idx    = (n_cnt_q >= SPS_C) ? n_cnt_q - SPS_C : n_cnt_q + SPS_C;
    assign slot_sym = hold_v_q ? (hold_bit_q ? SYM_POS : SYM_NEG) : SYM_ZERO;

    always_comb begin
        n_cnt_d    = n_cnt_q;
        sym_i_d    = sym_i_q;
        sym_q_d    = sym_q_q;
        hold_v_d   = hold_v_q;
        hold_bit_d = hold_bit_q;
        i_d        = i_q;
        q_d        = q_q;
        vld_d      = 1'b0;
        under_d    = under_q;

        if (!en) begin
            n_cnt_d = '0;
            sym_i_d = SYM_ZERO;
            sym_q_d = SYM_ZERO;
            i_d     = '0;
            q_d     = '0;
            under_d = 1'b0;
        end else if (sample_en) begin
            // Symbol slots: I at n=0, Q at n=SPS; the loaded symbol shapes this very sample.
            if (n_cnt_q == '0 || n_cnt_q == SPS_C) begin
                if (hold_v_q) begin
                    hold_v_d = 1'b0;
                end else begin
                    under_d = 1'b1;
                end
                if (n_cnt_q == '0) begin
                    sym_i_d = slot_sym;
                end else begin
                    sym_q_d = slot_sym;
                end
            end
            i_d     = shape(sym_i_d, lut[n_cnt_q]);
            q_d     = shape(sym_q_d, lut[q_idx]);
            vld_d   = 1'b1;
            n_cnt_d = (n_cnt_q == LAST_C) ? '0 : n_cnt_q + 1'b1;
        end

        // Accept only when empty, so a transfer never collides with a consume.
        if (bit_tvalid && !hold_v_q) begin
            hold_v_d   = 1'b1;
            hold_bit_d = bit_tdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_cnt_q    <= '0;
            sym_i_q    <= SYM_ZERO;
            sym_q_q    <= SYM_ZERO;
            hold_v_q   <= 1'b0;
            hold_bit_q <= 1'b0;
            i_q        <= '0;
            q_q        <= '0;
            vld_q      <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            n_cnt_q    <= n_cnt_d;
            sym_i_q    <= sym_i_d;
            sym_q_q    <= sym_q_d;
            hold_v_q   <= hold_v_d;
            hold_bit_q <= hold_bit_d;
            i_q        <= i_d;
            q_q        <= q_d;
            vld_q      <= vld_d;
            under_q    <= under_d;
        end
    end

    assign bit_tready = ~hold_v_q;
    assign I_data     = i_q;
    assign Q_data     = q_q;
    assign out_valid  = vld_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_msk_bb_mod.sv
// tb_msk_bb_mod: randomized self-checking bench for msk_bb_mod (SPS=4, AMP=16384).
// Latency: expects each strobe exactly one clk after its sample_en cycle.
// Backpressure: the bench models the one-entry holding register and checks bit_tready every cycle.
module tb_msk_bb_mod;
    localparam int SPS = 4;
    localparam int AMP = 16384;

    logic clk = 1'b0;
    logic reset, en, sample_en, bit_tdata, bit_tvalid;
    logic bit_tready, out_valid, underrun;
    logic signed [15:0] I_data, Q_data;

    always #5 clk = ~clk;

    msk_bb_mod #(.SPS(SPS), .AMP(AMP)) dut (
        .clk(clk), .reset(reset), .en(en), .sample_en(sample_en),
        .bit_tdata(bit_tdata), .bit_tvalid(bit_tvalid), .bit_tready(bit_tready),
        .I_data(I_data), .Q_data(Q_data), .out_valid(out_valid), .underrun(underrun)
    );

    typedef struct { int cyc; int i; int q; } exp_t;

    exp_t sb[$];
    int   obs_i[$], obs_q[$];
    bit   src[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, rst_cnt = 0, clr_cnt = 0, rdy_hi = 0;

    // Reference model: sample index since en rose, symbol lists per rail, bit buffer occupancy.
    bit   m_hold_v = 0, m_hold_bit = 0, m_under = 0, last_xfer = 0;
    int   s = 0;
    int   isym[$], qsym[$];

    int exp1_i[8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};
    int exp1_q[8] = '{0, 0, 0, 0, 0, -6270, -11585, -15137};

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Half-sine pulse p(t), zero outside one bit-pair period.
    function automatic int pulse(int t);
        if (t < 0 || t >= 2 * SPS) return 0;
        return $rtoi(real'(AMP) * $sin(3.14159265358979 * real'(t) / real'(2 * SPS)) + 0.5);
    endfunction

    task automatic model_reset();
        m_hold_v = 0; m_hold_bit = 0; m_under = 0; s = 0;
        isym.delete(); qsym.delete();
    endtask

    task automatic model_edge();
        int v, ei, eq;
        exp_t e;
        last_xfer = 0;
        if (reset) begin
            model_reset();
            return;
        end
        last_xfer = bit_tvalid && !m_hold_v;
        if (!en) begin
            s = 0; isym.delete(); qsym.delete(); m_under = 0;
            clr_cnt++;
        end else if (sample_en) begin
            if (s % SPS == 0) begin
                if (m_hold_v) begin
                    v = m_hold_bit ? 1 : -1;
                    m_hold_v = 0;
                end else begin
                    v = 0;
                    m_under = 1;
                end
                if ((s / SPS) % 2 == 0) isym.push_back(v);
                else qsym.push_back(v);
            end
            ei = isym[s / (2 * SPS)] * pulse(s % (2 * SPS));
            eq = (s >= SPS) ? qsym[(s - SPS) / (2 * SPS)] * pulse((s - SPS) % (2 * SPS)) : 0;
            e.cyc = cyc; e.i = ei; e.q = eq;
            sb.push_back(e);
            s++;
        end
        if (last_xfer) begin
            m_hold_v = 1;
            m_hold_bit = bit_tdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic run_clks(int n, int period, bit rnd);
        for (int c = 0; c < n; c++) begin
            sample_en  = rnd ? 1'($urandom_range(0, 1)) : ((c % period) == period - 1);
            bit_tvalid = (src.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            bit_tdata  = (src.size() > 0) ? src[0] : 1'b0;
            tick();
            if (last_xfer) void'(src.pop_front());
            if (bit_tready) rdy_hi++;
        end
        sample_en = 0;
        bit_tvalid = 0;
    endtask

    task automatic idle(int n);
        sample_en = 0;
        bit_tvalid = 0;
        repeat (n) tick();
    endtask

    task automatic add_random_bits(int n);
        for (int k = 0; k < n; k++) src.push_back(1'($urandom_range(0, 1)));
    endtask

    // Monitor: pops the scoreboard on every strobe, checks hold, tready and underrun each cycle.
    initial begin : monitor
        int   seen_rst, seen_clr, cur_i, cur_q;
        exp_t e;
        seen_rst = 0; seen_clr = 0; cur_i = 0; cur_q = 0;
        forever begin
            @(negedge clk);
            if (rst_cnt != seen_rst) begin
                seen_rst = rst_cnt; sb.delete(); cur_i = 0; cur_q = 0;
            end
            if (clr_cnt != seen_clr) begin
                seen_clr = clr_cnt; cur_i = 0; cur_q = 0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("strobe_unexpected", int'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_latency", cyc - e.cyc, 0);
                    check("I_sample", int'(I_data), e.i);
                    check("Q_sample", int'(Q_data), e.q);
                    cur_i = e.i; cur_q = e.q;
                    obs_i.push_back(int'(I_data));
                    obs_q.push_back(int'(Q_data));
                end
            end else begin
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    check("strobe_missing", int'(out_valid), 1);
                    void'(sb.pop_front());
                end
                check("I_hold", int'(I_data), cur_i);
                check("Q_hold", int'(Q_data), cur_q);
            end
            check("tready", int'(bit_tready), int'(!m_hold_v));
            check("underrun", int'(underrun), int'(m_under));
        end
    end

    initial begin : driver
        int base;
        bit kept;
        reset = 1; en = 0; sample_en = 0; bit_tdata = 0; bit_tvalid = 0;
        repeat (3) tick();
        check("rst_I", int'(I_data), 0);
        check("rst_Q", int'(Q_data), 0);
        check("rst_vld", int'(out_valid), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_tready", int'(bit_tready), 1);
        reset = 0;
        idle(1);

        // Bits 1,0 preloaded, one sample per clk.
        src = '{1'b1, 1'b0};
        run_clks(1, 1, 0);
        en = 1;
        base = obs_i.size();
        run_clks(8, 1, 0);
        idle(1);
        check("p1_count", obs_i.size() - base, 8);
        if (obs_i.size() - base >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("p1_I", obs_i[base + k], exp1_i[k]);
                check("p1_Q", obs_q[base + k], exp1_q[k]);
            end
        end
        en = 0; idle(2);

        // Bits 1,1,0,1 with sample_en every third clk.
        src = '{1'b1, 1'b1, 1'b0, 1'b1};
        en = 1;
        base = obs_i.size();
        run_clks(12 * SPS, 3, 0);
        idle(1);
        check("p2_count", obs_i.size() - base, 4 * SPS);
        if (obs_i.size() - base >= 4 * SPS) begin
            check("p2_I_neg_k1", obs_i[base + 2 * SPS + 1], -6270);
            check("p2_Q_pos_k1", obs_q[base + SPS + 1], 6270);
        end
        en = 0; idle(2);

        // Only one bit available: Q slot underruns, I pulse completes.
        src = '{1'b1};
        en = 1;
        base = obs_i.size();
        run_clks(4 * SPS, 2, 0);
        idle(1);
        check("p3_count", obs_i.size() - base, 2 * SPS);
        check("p3_underrun", int'(underrun), 1);
        if (obs_i.size() - base >= 2 * SPS) begin
            check("p3_I_peak", obs_i[base + SPS], AMP);
            check("p3_Q_zero", obs_q[base + SPS + 1], 0);
        end
        en = 0; idle(2);

        // Continuous bit_tvalid: one accept per SPS samples, 64 random bits in order.
        add_random_bits(64);
        en = 1;
        run_clks(4 * SPS, 1, 0);
        rdy_hi = 0;
        run_clks(16 * SPS, 1, 0);
        check("bp_tready_per_sps", rdy_hi, 16);
        run_clks(48 * SPS + 2 * SPS + 8, 1, 0);
        check("bp_all_bits_taken", src.size(), 0);
        en = 0; idle(2);

        // en dropped at n_cnt=5 with a bit pending.
        en = 1;
        run_clks(2, 2, 0);
        add_random_bits(8);
        run_clks(9, 2, 0);
        src.delete();
        kept = m_hold_bit;
        en = 0;
        run_clks(1, 1, 0);
        check("drop_I", int'(I_data), 0);
        check("drop_Q", int'(Q_data), 0);
        check("drop_underrun", int'(underrun), 0);
        check("drop_vld", int'(out_valid), 0);
        check("drop_tready", int'(bit_tready), 0);
        idle(2);
        en = 1;
        base = obs_i.size();
        run_clks(2, 1, 0);
        idle(1);
        check("resume_count", obs_i.size() - base, 2);
        if (obs_i.size() - base >= 2) begin
            check("resume_I_k0", obs_i[base], 0);
            check("resume_I_k1", obs_i[base + 1], kept ? 6270 : -6270);
        end

        // Async reset between edges while streaming.
        en = 0; idle(2);
        add_random_bits(16);
        en = 1;
        run_clks(5 * SPS + 3, 1, 0);
        #2 reset = 1;
        #1;
        check("arst_I", int'(I_data), 0);
        check("arst_Q", int'(Q_data), 0);
        check("arst_vld", int'(out_valid), 0);
        check("arst_underrun", int'(underrun), 0);
        check("arst_tready", int'(bit_tready), 1);
        rst_cnt++;
        model_reset();
        tick();
        reset = 0;
        src.delete();
        add_random_bits(8);
        run_clks(6 * SPS, 1, 0);

        // Random cadence and random bit availability.
        en = 0; idle(2);
        add_random_bits(40);
        en = 1;
        run_clks(300, 1, 1);
        en = 0;
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
